// File: rtl/lms_pkg.sv
// Shared LMS definitions: default sizes, adaptation FSM states and the
// coefficient bank type, reused by the coefficient updater and the FIR.
package lms_pkg;

  localparam int NTAPS = 16;
  localparam int DW    = 16;
  localparam int CW    = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef logic [NTAPS-1:0][CW-1:0] coeff_arr_t;

endpackage

// File: rtl/lms_coeff_update_if.sv
// Sample/control bundle between the sample source and the LMS coefficient
// updater, plus the coefficient bank the updater drives towards the FIR.
interface lms_coeff_update_if #(
  parameter int NTAPS = lms_pkg::NTAPS,
  parameter int DW    = lms_pkg::DW,
  parameter int CW    = lms_pkg::CW
) ();

  // sample_valid is a single-cycle strobe with no ready: it is taken only while
  // busy is low; a strobe seen while busy is high is dropped and sets overrun.
  logic                         sample_valid;
  logic signed [DW-1:0]         ref_in;
  logic signed [DW-1:0]         err_in;
  logic [4:0]                   mu_shift;
  logic                         freeze;
  logic                         clear_coeffs;
  logic                         busy;
  logic                         update_done;
  logic                         overrun;
  logic [NTAPS-1:0][CW-1:0]     filt_coeffs_b;

  modport master (
    output sample_valid, ref_in, err_in, mu_shift, freeze, clear_coeffs,
    input  busy, update_done, overrun, filt_coeffs_b
  );

  modport slave (
    input  sample_valid, ref_in, err_in, mu_shift, freeze, clear_coeffs,
    output busy, update_done, overrun, filt_coeffs_b
  );

endinterface

// File: rtl/sat_add.sv
// Signed add at CW+1 bits, saturated back to the CW-bit coefficient range.
module sat_add #(
  parameter int CW = 32
) (
  input  logic signed [CW:0] a_i,
  input  logic signed [CW:0] b_i,
  output logic [CW-1:0]      sum_o
);

  logic signed [CW:0] sum;

  always_comb begin
    sum = a_i + b_i;
    // Operands are sign-extended CW-bit values, so overflow shows as the two MSBs differing.
    if (sum[CW] != sum[CW-1]) begin
      sum_o = sum[CW] ? {1'b1, {(CW-1){1'b0}}} : {1'b0, {(CW-1){1'b1}}};
    end else begin
      sum_o = sum[CW-1:0];
    end
  end

endmodule

// File: rtl/lms_coeff_update.sv
// LMS coefficient updater: on each accepted sample, shift the reference delay
// line and walk the taps one per cycle through a single shared multiplier.
module lms_coeff_update #(
  parameter int NTAPS = lms_pkg::NTAPS,
  parameter int DW    = lms_pkg::DW,
  parameter int CW    = lms_pkg::CW
) (
  input  logic              clk,
  input  logic              rst_n,
  lms_coeff_update_if.slave bus,
  output lms_pkg::state_e   dbg_state_o
);

  import lms_pkg::*;

  localparam int KW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  state_e                   state_q;
  logic [KW-1:0]            k_q;
  logic signed [DW-1:0]     err_q;
  logic [4:0]               mu_q;
  logic [NTAPS-1:0][DW-1:0] ref_q;
  logic [NTAPS-1:0][CW-1:0] coeff_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     overrun_q;

  logic signed [2*DW-1:0]   prod;
  logic signed [2*DW-1:0]   prod_sh;
  logic signed [CW:0]       coeff_ext;
  logic signed [CW:0]       inc_ext;
  logic [CW-1:0]            coeff_d;

  // Assumes 2*DW <= CW so the shifted product always fits the CW+1-bit add.
  always_comb begin
    prod      = (2*DW)'(err_q) * (2*DW)'($signed(ref_q[k_q]));
    prod_sh   = prod >>> mu_q;
    coeff_ext = (CW+1)'($signed(coeff_q[k_q]));
    inc_ext   = (CW+1)'(prod_sh);
  end

  sat_add #(.CW(CW)) u_sat_add (
    .a_i   (coeff_ext),
    .b_i   (inc_ext),
    .sum_o (coeff_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      err_q     <= '0;
      mu_q      <= '0;
      ref_q     <= '0;
      coeff_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else if (bus.clear_coeffs) begin
      state_q   <= IDLE;
      k_q       <= '0;
      ref_q     <= '0;
      coeff_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.sample_valid && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (bus.sample_valid) begin
            for (int i = NTAPS-1; i > 0; i--) begin
              ref_q[i] <= ref_q[i-1];
            end
            ref_q[0] <= bus.ref_in;
            err_q    <= bus.err_in;
            mu_q     <= bus.mu_shift;
            k_q      <= '0;
            busy_q   <= 1'b1;
            state_q  <= bus.freeze ? DONE : UPDATE;
          end
        end
        UPDATE: begin
          coeff_q[k_q] <= coeff_d;
          if (k_q == KW'(NTAPS-1)) begin
            state_q <= DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DONE: begin
          // The pulse lands in the first IDLE cycle, which is also the next acceptance slot.
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.update_done   = done_q;
  assign bus.overrun       = overrun_q;
  assign bus.filt_coeffs_b = coeff_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_lms_coeff_update.sv
// Bench for lms_coeff_update: a tap-level reference model pushes expected
// coefficient banks into a queue that is drained on each update_done.
module tb_lms_coeff_update;
  import lms_pkg::*;

  logic   clk;
  logic   rst_n;
  state_e dbg_state;

  int tests;
  int fails;

  logic [CW-1:0] exp_q[$];
  longint        m_coef[NTAPS];
  longint        m_ref[NTAPS];

  lms_coeff_update_if #(.NTAPS(NTAPS), .DW(DW), .CW(CW)) bus ();

  lms_coeff_update #(.NTAPS(NTAPS), .DW(DW), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n            = 1'b0;
    bus.sample_valid = 1'b0;
    bus.ref_in       = '0;
    bus.err_in       = '0;
    bus.mu_shift     = '0;
    bus.freeze       = 1'b0;
    bus.clear_coeffs = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_zero();
  endtask

  // ---------------- reference model ----------------
  task automatic model_zero();
    for (int i = 0; i < NTAPS; i++) begin
      m_coef[i] = 0;
      m_ref[i]  = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_step(int r, int e, int mu, bit frz);
    longint p;
    longint s;
    longint cmax;
    longint cmin;
    cmax = (longint'(1) <<< (CW-1)) - 1;
    cmin = -(longint'(1) <<< (CW-1));
    for (int i = NTAPS-1; i > 0; i--) m_ref[i] = m_ref[i-1];
    m_ref[0] = r;
    if (!frz) begin
      for (int k = 0; k < NTAPS; k++) begin
        p = longint'(e) * m_ref[k];
        p = p >>> mu;
        s = m_coef[k] + p;
        if (s > cmax) s = cmax;
        if (s < cmin) s = cmin;
        m_coef[k] = s;
      end
    end
    for (int k = 0; k < NTAPS; k++) exp_q.push_back(CW'(m_coef[k]));
  endtask

  // ---------------- driver + scoreboard drain ----------------
  // Drives one accepted sample, optionally injects a strobe at pass cycle inj_at,
  // scrambles mu_shift/freeze mid-pass, then checks latency and the whole bank.
  task automatic send(int r, int e, int mu, bit frz, int inj_at);
    int            cyc;
    int            exp_lat;
    logic [CW-1:0] exp_c;
    model_step(r, e, mu, frz);
    bus.sample_valid = 1'b1;
    bus.ref_in       = DW'(r);
    bus.err_in       = DW'(e);
    bus.mu_shift     = 5'(mu);
    bus.freeze       = frz;
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    bus.mu_shift     = 5'($urandom_range(0, 31));
    bus.freeze       = 1'($urandom_range(0, 1));
    bus.err_in       = DW'($urandom_range(0, 65535));
    cyc = 0;
    while (bus.update_done !== 1'b1 && cyc < 200) begin
      bus.sample_valid = (inj_at > 0 && cyc == inj_at);
      if (bus.sample_valid) bus.ref_in = DW'(99);
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.sample_valid = 1'b0;
    bus.freeze       = 1'b0;
    exp_lat = frz ? 1 : NTAPS + 1;
    tests++;
    if (cyc != exp_lat) begin
      fails++;
      $display("FAIL done_latency: got %0d cycles, expected %0d", cyc, exp_lat);
    end
    for (int i = 0; i < NTAPS; i++) begin
      exp_c = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      tests++;
      if (bus.filt_coeffs_b[i] !== exp_c) begin
        fails++;
        $display("FAIL coeff[%0d]: got %0d, expected %0d", i,
                 $signed(bus.filt_coeffs_b[i]), $signed(exp_c));
      end
    end
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_after_pass: got %b, expected 0", bus.busy);
    end
  endtask

  task automatic pulse_clear();
    bus.clear_coeffs = 1'b1;
    @(posedge clk);
    #1 bus.clear_coeffs = 1'b0;
    model_zero();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    tests++;
    if (bus.busy !== 1'b0 || bus.update_done !== 1'b0 || bus.overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: got busy=%b done=%b ovr=%b, expected 0 0 0",
               bus.busy, bus.update_done, bus.overrun);
    end
    tests++;
    if (bus.filt_coeffs_b !== '0) begin
      fails++;
      $display("FAIL reset_coeffs: got %h, expected all zero", bus.filt_coeffs_b);
    end
    tests++;
    if (dbg_state !== IDLE) begin
      fails++;
      $display("FAIL reset_state: got %0d, expected %0d", dbg_state, IDLE);
    end
  endtask

  task automatic test_single_step();
    send(100, 3, 0, 1'b0, 0);
    tests++;
    if (bus.filt_coeffs_b[0] !== CW'(300)) begin
      fails++;
      $display("FAIL single_c0: got %0d, expected 300", $signed(bus.filt_coeffs_b[0]));
    end
  endtask

  task automatic test_delay_line();
    int exp_v[4] = '{10, 6, 3, 1};
    pulse_clear();
    for (int s = 1; s <= 4; s++) send(s, 1, 0, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (bus.filt_coeffs_b[i] !== CW'(exp_v[i])) begin
        fails++;
        $display("FAIL delay_c%0d: got %0d, expected %0d", i,
                 $signed(bus.filt_coeffs_b[i]), exp_v[i]);
      end
    end
  endtask

  task automatic test_saturation();
    pulse_clear();
    repeat (3) send(-32768, -32768, 0, 1'b0, 0);
    tests++;
    if (bus.filt_coeffs_b[0] !== 32'h7FFF_FFFF) begin
      fails++;
      $display("FAIL sat_c0: got %0d, expected 2147483647", $signed(bus.filt_coeffs_b[0]));
    end
  endtask

  task automatic test_floor_shift();
    pulse_clear();
    send(-1, 1, 4, 1'b0, 0);
    tests++;
    if (bus.filt_coeffs_b[0] !== CW'(-1)) begin
      fails++;
      $display("FAIL floor_c0: got %0d, expected -1", $signed(bus.filt_coeffs_b[0]));
    end
  endtask

  task automatic test_overrun();
    pulse_clear();
    send(5, 2, 0, 1'b0, 5);
    tests++;
    if (bus.overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set: got %b, expected 1", bus.overrun);
    end
    // Next sample exposes the delay line: c[1] grows by 5 only if 99 was dropped.
    send(1, 1, 0, 1'b0, 0);
    tests++;
    if (bus.overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_sticky: got %b, expected 1", bus.overrun);
    end
  endtask

  task automatic test_freeze();
    send(7, 9, 0, 1'b1, 0);
    send(0, 1, 0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 6; n++) begin
      send($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
           $urandom_range(0, 31), 1'($urandom_range(0, 3) == 0), 0);
    end
  endtask

  task automatic test_clear_abort();
    int seen_done;
    bus.sample_valid = 1'b1;
    bus.ref_in       = DW'(1234);
    bus.err_in       = DW'(-55);
    @(posedge clk);
    #1 bus.sample_valid = 1'b1;
    @(posedge clk);
    #1 bus.sample_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 bus.clear_coeffs = 1'b1;
    @(posedge clk);
    #1 bus.clear_coeffs = 1'b0;
    model_zero();
    tests++;
    if (bus.filt_coeffs_b !== '0 || bus.overrun !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL clear_abort: got ovr=%b busy=%b coeffs=%h, expected zeros",
               bus.overrun, bus.busy, bus.filt_coeffs_b);
    end
    tests++;
    if (dbg_state !== IDLE) begin
      fails++;
      $display("FAIL clear_state: got %0d, expected %0d", dbg_state, IDLE);
    end
    seen_done = 0;
    repeat (20) begin
      if (bus.update_done === 1'b1) seen_done++;
      @(posedge clk);
      #1;
    end
    tests++;
    if (seen_done != 0) begin
      fails++;
      $display("FAIL clear_no_done: got %0d pulses, expected 0", seen_done);
    end
  endtask

  task automatic test_reset_abort();
    send(300, 40, 2, 1'b0, 3);
    bus.sample_valid = 1'b1;
    bus.ref_in       = DW'(-700);
    bus.err_in       = DW'(21);
    @(posedge clk);
    #1 bus.sample_valid = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.filt_coeffs_b !== '0 || bus.busy !== 1'b0 || bus.overrun !== 1'b0 ||
        bus.update_done !== 1'b0 || dbg_state !== IDLE) begin
      fails++;
      $display("FAIL async_reset: got busy=%b ovr=%b done=%b st=%0d coeffs=%h, expected idle zeros",
               bus.busy, bus.overrun, bus.update_done, dbg_state, bus.filt_coeffs_b);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_zero();
    send(100, 3, 0, 1'b0, 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single_step();
    test_delay_line();
    test_saturation();
    test_floor_shift();
    test_overrun();
    test_freeze();
    test_back_to_back();
    test_clear_abort();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
